// File: rtl/rr_lane_arbiter_if.sv
// Handshake bundle between the lane requesters and the round-robin lane arbiter.
// The arbiter takes the slave side; the requesters (or the bench) take the master side.
interface rr_lane_arbiter_if #(
  parameter int N   = 3,
  parameter int IDW = $clog2(N)
);
  logic           i_en;
  logic [N-1:0]   i_req;
  logic [N-1:0]   i_done;
  logic [N-1:0]   o_gnt;
  logic [IDW-1:0] o_gnt_id;
  logic           o_busy;
  logic           o_timeout;

  modport master (
    output i_en, i_req, i_done,
    input  o_gnt, o_gnt_id, o_busy, o_timeout
  );

  modport slave (
    input  i_en, i_req, i_done,
    output o_gnt, o_gnt_id, o_busy, o_timeout
  );
endinterface

// File: rtl/rr_lane_arbiter.sv
// Round-robin owner selection for the shared output lane: registered one-hot grant,
// bounded tenure, and a mandatory one-cycle gap between successive owners.
module rr_lane_arbiter #(
  parameter int N        = 3,
  parameter int HOLD_MAX = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  rr_lane_arbiter_if.slave bus
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t         state;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;
  logic [IDW-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_oh;
  logic           any_req;
  logic           own_req;
  logic           own_done;
  logic           hold_hit;
  logic           release_now;
  logic [IDW-1:0] ptr_next;
  int             idx;

  // Scan from ptr upward (mod N); iterating backwards leaves the first hit in win_id.
  always_comb begin
    win_id = '0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (bus.i_req[IDW'(idx)]) win_id = IDW'(idx);
    end
  end

  assign any_req     = |bus.i_req;
  assign win_oh      = N'(1) << win_id;
  assign own_req     = bus.i_req[gnt_id];
  assign own_done    = bus.i_done[gnt_id];
  assign hold_hit    = (HOLD_MAX != 0) && (cnt == HOLD_LIM);
  assign release_now = !own_req || own_done || hold_hit;
  assign ptr_next    = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        GRANT: begin
          if (release_now) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= ptr_next;
            timeout <= hold_hit && own_req && !own_done;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // IDLE and GAP arbitrate identically; a GAP with no winner falls to IDLE.
          if (bus.i_en && any_req) begin
            state  <= GRANT;
            gnt    <= win_oh;
            gnt_id <= win_id;
            busy   <= 1'b1;
            cnt    <= CNT_W'(1);
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.o_gnt     = gnt;
  assign bus.o_gnt_id  = gnt_id;
  assign bus.o_busy    = busy;
  assign bus.o_timeout = timeout;

endmodule

// File: tb/tb_rr_lane_arbiter.sv
// Directed bench for rr_lane_arbiter (N=3, HOLD_MAX=8): reset, rotation, timeout,
// coincident release, enable gating and asynchronous reset during a tenure.
module tb_rr_lane_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  rr_lane_arbiter_if #(.N(3), .IDW(2)) bus ();

  rr_lane_arbiter #(.N(3), .HOLD_MAX(8), .IDW(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.i_en   = 1'b1;
    bus.i_req  = '0;
    bus.i_done = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.i_en   = 1'b1;
    bus.i_req  = 3'b111;
    bus.i_done = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0 || bus.o_timeout !== 1'b0 ||
          bus.o_gnt_id !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: gnt=%b busy=%b to=%b id=%0d, required gnt=000 busy=0 to=0 id=0",
                 i, bus.o_gnt, bus.o_busy, bus.o_timeout, bus.o_gnt_id);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.o_gnt !== 3'b001 || bus.o_gnt_id !== 2'd0 || bus.o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant: gnt=%b id=%0d busy=%b, required gnt=001 id=0 busy=1",
               bus.o_gnt, bus.o_gnt_id, bus.o_busy);
    end
    bus.i_req = '0;
  endtask

  task automatic test_rotation();
    logic [2:0] exp_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] exp_id  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    bus.i_req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      tick();
      vectors++;
      if (bus.o_gnt !== exp_gnt[t] || bus.o_gnt_id !== exp_id[t]) begin
        miscompares++;
        $display("FAIL rotation_c1[%0d]: gnt=%b id=%0d, required gnt=%b id=%0d",
                 t, bus.o_gnt, bus.o_gnt_id, exp_gnt[t], exp_id[t]);
      end
      tick();
      vectors++;
      if (bus.o_gnt !== exp_gnt[t]) begin
        miscompares++;
        $display("FAIL rotation_c2[%0d]: gnt=%b, required %b", t, bus.o_gnt, exp_gnt[t]);
      end
      bus.i_done = exp_gnt[t];
      tick();
      vectors++;
      if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0 || bus.o_timeout !== 1'b0 ||
          bus.o_gnt_id !== exp_id[t]) begin
        miscompares++;
        $display("FAIL rotation_gap[%0d]: gnt=%b busy=%b to=%b id=%0d, required gnt=000 busy=0 to=0 id=%0d",
                 t, bus.o_gnt, bus.o_busy, bus.o_timeout, bus.o_gnt_id, exp_id[t]);
      end
      bus.i_done = '0;
    end
    bus.i_req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.i_req = 3'b010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if (bus.o_gnt !== 3'b010 || bus.o_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_hold[%0d]: gnt=%b to=%b, required gnt=010 to=0",
                 k, bus.o_gnt, bus.o_timeout);
      end
    end
    tick();
    vectors++;
    if (bus.o_gnt !== 3'b000 || bus.o_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_gap: gnt=%b to=%b, required gnt=000 to=1", bus.o_gnt, bus.o_timeout);
    end
    tick();
    vectors++;
    if (bus.o_gnt !== 3'b010 || bus.o_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_regrant: gnt=%b to=%b, required gnt=010 to=0", bus.o_gnt, bus.o_timeout);
    end
    bus.i_req = '0;
  endtask

  task automatic test_coincident();
    // done on the limit cycle, then a dropped request on the limit cycle
    logic [2:0] req_v [2] = '{3'b010, 3'b001};
    for (int c = 0; c < 2; c++) begin
      do_reset();
      bus.i_req = req_v[c];
      for (int k = 1; k <= 8; k++) begin
        tick();
        vectors++;
        if (bus.o_gnt !== req_v[c]) begin
          miscompares++;
          $display("FAIL coincident_hold[%0d.%0d]: gnt=%b, required %b", c, k, bus.o_gnt, req_v[c]);
        end
      end
      if (c == 0) bus.i_done = req_v[c];
      else        bus.i_req  = '0;
      tick();
      vectors++;
      if (bus.o_gnt !== 3'b000 || bus.o_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL coincident_gap[%0d]: gnt=%b to=%b, required gnt=000 to=0",
                 c, bus.o_gnt, bus.o_timeout);
      end
      bus.i_done = '0;
      bus.i_req  = '0;
    end
  endtask

  task automatic test_enable();
    do_reset();
    bus.i_req = 3'b001;
    tick();
    vectors++;
    if (bus.o_gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL enable_first: gnt=%b, required 001", bus.o_gnt);
    end
    bus.i_en  = 1'b0;
    bus.i_req = 3'b111;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (bus.o_gnt !== 3'b001) begin
        miscompares++;
        $display("FAIL enable_persist[%0d]: gnt=%b, required 001", k, bus.o_gnt);
      end
    end
    bus.i_done = 3'b001;
    tick();
    bus.i_done = '0;
    vectors++;
    if (bus.o_gnt !== 3'b000) begin
      miscompares++;
      $display("FAIL enable_release: gnt=%b, required 000", bus.o_gnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL enable_blocked[%0d]: gnt=%b busy=%b, required gnt=000 busy=0",
                 k, bus.o_gnt, bus.o_busy);
      end
    end
    bus.i_en = 1'b1;
    tick();
    vectors++;
    if (bus.o_gnt !== 3'b010 || bus.o_gnt_id !== 2'd1) begin
      miscompares++;
      $display("FAIL enable_resume: gnt=%b id=%0d, required gnt=010 id=1", bus.o_gnt, bus.o_gnt_id);
    end
    bus.i_req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_req = 3'b100;
    tick();
    vectors++;
    if (bus.o_gnt !== 3'b100 || bus.o_gnt_id !== 2'd2) begin
      miscompares++;
      $display("FAIL async_pre: gnt=%b id=%0d, required gnt=100 id=2", bus.o_gnt, bus.o_gnt_id);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0 || bus.o_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL async_drop: gnt=%b busy=%b to=%b, required gnt=000 busy=0 to=0",
               bus.o_gnt, bus.o_busy, bus.o_timeout);
    end
    bus.i_req = 3'b110;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.o_gnt !== 3'b010 || bus.o_gnt_id !== 2'd1) begin
      miscompares++;
      $display("FAIL async_regrant: gnt=%b id=%0d, required gnt=010 id=1", bus.o_gnt, bus.o_gnt_id);
    end
    bus.i_req = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.i_en    = 1'b1;
    bus.i_req   = '0;
    bus.i_done  = '0;
    #2;
    test_reset();
    test_rotation();
    test_timeout();
    test_coincident();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_lane_arbiter.md
Name: rr_lane_arbiter

Overview:
- Round-robin arbiter that shares one hierarchical output lane (the a/b/c-style channel driven down through the M-level instance chain) among N requesters.
- Issues a registered one-hot grant to one requester at a time.
- Bounds each tenure with a hold-cycle limit.
- Inserts a one-cycle gap between tenures so downstream muxing never sees two owners in adjacent cycles.
- Sits in top, beside the instance chain, and drives the lane-select of the shared resource.

Parameters:
N, 3, number of requesters (N>=2)
HOLD_MAX, 8, max consecutive grant cycles per tenure; 0 = unlimited (no timeout)
IDW, $clog2(N), width of o_gnt_id

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  asynchronous, active-high reset
i_en  input  1  arbitration enable; low blocks new grants, current tenure completes
i_req  input  N  per-requester request, level
i_done  input  N  per-requester release pulse, honoured only for the current owner
o_gnt  output  N  one-hot grant, registered
o_gnt_id  output  IDW  index of current owner; holds last owner when no grant
o_busy  output  1  high while any grant is asserted
o_timeout  output  1  one-cycle pulse when a tenure is force-ended by HOLD_MAX

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_gnt=0, o_gnt_id=0, o_busy=0, o_timeout=0, ptr=0, cnt=0. Asserting reset mid-tenure drops the grant immediately with no timeout pulse.
- States: IDLE, GRANT, GAP.
- Arbitration (performed in IDLE and GAP only):
  - Applies when i_en=1 and |i_req.
  - Winner = first i with i_req[i]=1, scanning ptr, ptr+1, ... mod N.
  - Next cycle: state=GRANT, o_gnt=onehot(winner), o_gnt_id=winner, cnt=1.
  - Latency: request sampled in cycle t gives a grant in cycle t+1.
- GRANT, owner g:
  - Release when i_req[g]=0, or i_done[g]=1, or (HOLD_MAX!=0 and cnt==HOLD_MAX).
  - On release: next cycle state=GAP, o_gnt=0, ptr=(g+1) mod N.
  - Otherwise cnt increments. cnt is never compared when HOLD_MAX=0; it saturates at its maximum.
- o_timeout:
  - Set for exactly one cycle (the GAP cycle) iff the release cause was only cnt==HOLD_MAX, i.e. i_req[g]=1 and i_done[g]=0.
  - If i_done[g] or a dropped request coincides with cnt==HOLD_MAX, there is no timeout.
- GAP: o_gnt=0 for exactly one cycle; arbitrates as IDLE. With a request present the next state is GRANT, otherwise IDLE.
- Back-to-back: minimum spacing between two tenures is one gap cycle. A releasing owner still requesting becomes lowest priority, which guarantees fairness.
- i_done and i_req of non-owners are ignored during GRANT.
- i_en=0 in GRANT has no effect on the current tenure. After release the block waits in IDLE/GAP until i_en=1.
- o_busy = |o_gnt (registered with it).
- o_gnt is never multi-hot.

Test Plan:
- Reset/idle: i_rst pulse with i_req=3'b111 during reset -> o_gnt=0 throughout reset; o_gnt=3'b001 the first cycle after deassert + 1.
- Rotation: i_req=3'b111 held, HOLD_MAX=8, i_done pulses on the owner's 2nd grant cycle -> grant sequence 001,gap,010,gap,100,gap,001, each tenure 2 cycles.
- Timeout: i_req=3'b010 held, no i_done, HOLD_MAX=8 -> o_gnt=010 for exactly 8 cycles, then one GAP cycle with o_timeout=1, then re-grant 010.
- Coincident release: i_done[g] asserted on cnt==HOLD_MAX -> GAP follows, o_timeout stays 0.
- Enable: i_en dropped mid-tenure -> current grant persists until i_done. No further grants while i_en=0. First grant one cycle after i_en=1 goes to the requester at ptr.
- Async reset mid-tenure: i_rst asserted between clock edges while o_gnt=100 -> o_gnt=0 and o_busy=0 without a clock edge; ptr=0, so next grant goes to lowest requesting index.
